data_bus_unit: RTL

//  Slave on the CPU data bus (DA/DD/RW): word RAM plus memory-mapped I/O (LED register, switch input, UART TX with FIFO, optional timer).

---
 rtl/data_bus_unit_pkg.sv | 24 ++
 rtl/dbu_uart_tx.sv | 131 +++++++++++++
 rtl/data_bus_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/data_bus_unit_pkg.sv
// rtl/data_bus_unit_pkg.sv - shared address map, TX FSM states and RAM decode helper
// Purpose: constants shared by data_bus_unit and dbu_uart_tx.
// Ports: none (package).
package data_bus_unit_pkg;

  localparam logic [15:0] ADDR_LED    = 16'hFF00;
  localparam logic [15:0] ADDR_SW     = 16'hFF01;
  localparam logic [15:0] ADDR_TXDATA = 16'hFF02;
  localparam logic [15:0] ADDR_STATUS = 16'hFF03;
  localparam logic [15:0] ADDR_TIMER  = 16'hFF04;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // RAM occupies 0 .. 2**aw-1; the compare is widened so aw=16 still works.
  function automatic logic in_ram(input logic [15:0] a, input int aw);
    return ({1'b0, a} < (17'd1 << aw));
  endfunction

endpackage

// File: rtl/dbu_uart_tx.sv
// rtl/dbu_uart_tx.sv - UART TX FIFO plus 8N1 serializer
// Purpose: queues bytes pushed from the bus and shifts them out LSB first.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data byte write request from the bus decoder
//   clr_ovf         clears the sticky overflow flag
//   txd             serial output (idle high)
//   empty, full     FIFO state
//   busy            serializer not idle
//   overflow        sticky: a push was dropped because the FIFO was full
module dbu_uart_tx
  import data_bus_unit_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       txd,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  tx_state_t     state;
  logic [DW-1:0] div;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          pop;
  logic          push_ok;
  logic          div_end;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign busy    = (state != TX_IDLE);
  assign pop     = (state == TX_IDLE) && !empty;
  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign push_ok = push && (!full || pop);
  assign div_end = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      txd     <= 1'b1;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          div <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            txd   <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (div_end) begin
            div     <= '0;
            bit_cnt <= '0;
            txd     <= shreg[0];
            state   <= TX_DATA;
          end else begin
            div <= div + DW'(1);
          end
        end
        TX_DATA: begin
          if (div_end) begin
            div <= '0;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        TX_STOP: begin
          if (div_end) begin
            div   <= '0;
            state <= TX_IDLE;
          end else begin
            div <= div + DW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_unit.sv
// rtl/data_bus_unit.sv - CPU data bus slave: word RAM and memory-mapped I/O
// Purpose: decodes DA, serves RAM, LED, synchronised switches, UART TX and
//   (with DATA_BUS_UNIT_TIMER_EN defined) a free-running timer at 0xFF04.
// Ports:
//   CK   clock            RST  synchronous active-high reset
//   DA   word address     DD   bidirectional data, driven only while RW==1
//   RW   1=read/idle, 0=write
//   SW   asynchronous switches   LED  LED register   TXD  UART serial out
module data_bus_unit
  import data_bus_unit_pkg::*;
#(
  parameter int AW         = 8,
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  output logic        TXD
);

  logic        wr;
  logic        ram_hit;
  logic [15:0] ram [2**AW];
  logic [15:0] sw_s1;
  logic [15:0] sw_s2;
  logic [15:0] timer_val;
  logic [15:0] rdata;
  logic        tx_empty, tx_full, tx_busy, tx_ovf;

  assign wr      = !RW && !RST;
  assign ram_hit = in_ram(DA, AW);

  // RAM has no reset so its contents survive RST.
  always_ff @(posedge CK) begin
    if (wr && ram_hit) ram[DA[AW-1:0]] <= DD;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      LED   <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      if (wr && DA == ADDR_LED) LED <= DD;
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

`ifdef DATA_BUS_UNIT_TIMER_EN
  always_ff @(posedge CK) begin
    if (RST)                     timer_val <= '0;
    else if (wr && DA == ADDR_TIMER) timer_val <= DD;
    else                         timer_val <= timer_val + 16'd1;
  end
`else
  assign timer_val = '0;
`endif

  dbu_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx (
    .clk       (CK),
    .rst       (RST),
    .push      (wr && DA == ADDR_TXDATA),
    .push_data (DD[7:0]),
    .clr_ovf   (wr && DA == ADDR_STATUS),
    .txd       (TXD),
    .empty     (tx_empty),
    .full      (tx_full),
    .busy      (tx_busy),
    .overflow  (tx_ovf)
  );

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[DA[AW-1:0]];
    end else begin
      case (DA)
        ADDR_LED:    rdata = LED;
        ADDR_SW:     rdata = sw_s2;
        ADDR_STATUS: rdata = {12'd0, tx_ovf, tx_busy, tx_full, tx_empty};
        ADDR_TIMER:  rdata = timer_val;
        default:     rdata = '0;
      endcase
    end
  end

  assign DD = RW ? rdata : 16'bz;

endmodule
